// File: rtl/digit_serial_add_sub_pkg.sv
// Shared encodings for the digit-serial arithmetic blocks.
// FSM states and operation-mode fields.
package digit_serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam logic FMT_UNS = 1'b0;
  localparam logic FMT_SGN = 1'b1;

  typedef struct packed {
    logic sub;
    logic sgn;
  } ser_mode_t;

  // Bit N of the full-precision result from the final-digit carry.
  function automatic logic ext_bit(
    input ser_mode_t m,
    input logic      co,
    input logic      a_msb,
    input logic      b_msb,
    input logic      s_msb
  );
    if (m.sgn == FMT_SGN)
      return (a_msb == b_msb) ? co : s_msb;
    else if (m.sub == OP_SUB)
      return ~co;
    else
      return co;
  endfunction

endpackage

// File: rtl/digit_serial_add_sub_add_digit.sv
// One D-bit slice of the serial adder.
// Pure combinational sum with carry in/out.
module add_digit #(
  parameter int D = 2
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         ci,
  output logic [D-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{D{1'b0}}, ci};

endmodule

// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor, LSB-first, D bits per cycle.
// Produces an (N+1)-bit full-precision result.
module digit_serial_add_sub
  import digit_serial_add_sub_pkg::*;
#(
  parameter int N = 8,
  parameter int M = N,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic         sgn,
  input  logic [N-1:0] A,
  input  logic [M-1:0] B,
  output logic [N:0]   O,
  output logic         busy,
  output logic         done
);

  localparam int DIGITS = N / D;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  ser_state_e      state;
  ser_mode_t       mode;
  logic [N-1:0]    bb;
  logic [N-1:0]    bx;
  logic [N-1:0]    a_sr;
  logic [N-1:0]    b_sr;
  logic [N-1:0]    sum_up;
  logic [D-1:0]    sum;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic            co;
  logic            a_msb;
  logic            b_msb;
  logic            last;

  always_comb begin
    bb = (sgn == FMT_SGN) ? N'($signed(B)) : N'(B);
    bx = bb ^ {N{sub}};
  end

  add_digit #(.D(D)) u_add (
    .a  (a_sr[D-1:0]),
    .b  (b_sr[D-1:0]),
    .ci (carry),
    .s  (sum),
    .co (co)
  );

  // New digit enters at the top; after DIGITS shifts it is aligned.
  assign sum_up = N'(sum) << (N - D);
  assign last = (cnt == CW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mode  <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      O     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          a_sr       <= a_sr >> D;
          b_sr       <= b_sr >> D;
          carry      <= co;
          cnt        <= cnt + 1'b1;
          O[N-1:0]   <= (O[N-1:0] >> D) | sum_up;
          if (last) begin
            O[N]  <= ext_bit(mode, co, a_msb, b_msb, sum[D-1]);
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            mode  <= '{sub: sub, sgn: sgn};
            a_sr  <= A;
            b_sr  <= bx;
            a_msb <= A[N-1];
            b_msb <= bx[N-1];
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Directed and random checks for digit_serial_add_sub.
// Four instances: D=2, M=4 (D=2), D=1, D=8.
module tb_digit_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic       sgn = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic [8:0] o [4];
  logic       busy_v [4];
  logic       done_v [4];

  int         lat [4];
  logic [8:0] res [4];
  int         tests = 0;
  int         fails = 0;
  int         t1, t2;
  logic [8:0] r1, r2;

  always #5 clk = ~clk;

  digit_serial_add_sub #(.N(8), .M(8), .D(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .sgn(sgn),
    .A(a), .B(b), .O(o[0]), .busy(busy_v[0]), .done(done_v[0])
  );
  digit_serial_add_sub #(.N(8), .M(4), .D(2)) u_m4 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .sgn(sgn),
    .A(a), .B(b[3:0]), .O(o[1]), .busy(busy_v[1]), .done(done_v[1])
  );
  digit_serial_add_sub #(.N(8), .M(8), .D(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .sgn(sgn),
    .A(a), .B(b), .O(o[2]), .busy(busy_v[2]), .done(done_v[2])
  );
  digit_serial_add_sub #(.N(8), .M(8), .D(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .sgn(sgn),
    .A(a), .B(b), .O(o[3]), .busy(busy_v[3]), .done(done_v[3])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic s, input logic g,
                                       input logic [7:0] x,
                                       input logic [7:0] y);
    int xv, yv, r;
    logic [31:0] rv;
    xv = g ? int'($signed(x)) : int'(x);
    yv = g ? int'($signed(y)) : int'(y);
    r  = s ? xv - yv : xv + yv;
    rv = r;
    return rv[8:0];
  endfunction

  task automatic go(input logic s, input logic g, input logic [7:0] x,
                    input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; sub = s; sgn = g; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input int skip);
    for (int i = 0; i < 4; i++) begin
      lat[i] = 0;
      res[i] = '0;
    end
    for (int c = skip + 1; c <= skip + 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (done_v[i] && lat[i] == 0) begin
          lat[i] = c;
          res[i] = o[i];
        end
    end
  endtask

  initial begin
    #12;
    for (int i = 0; i < 4; i++) begin
      chk("rst_o", 32'(o[i]), 32'h0);
      chk("rst_busy", 32'(busy_v[i]), 32'h0);
      chk("rst_done", 32'(done_v[i]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;

    go(1'b1, 1'b0, 8'h05, 8'h07);
    collect(0);
    chk("usub_o", 32'(res[0]), 32'h1FE);
    chk("usub_lat", lat[0], 4);
    chk("usub_d1", 32'(res[2]), 32'h1FE);
    chk("usub_d8", 32'(res[3]), 32'h1FE);

    go(1'b0, 1'b0, 8'hC8, 8'h64);
    collect(0);
    chk("uadd_o", 32'(res[0]), 32'h12C);
    chk("uadd_lat", lat[0], 4);

    go(1'b1, 1'b1, 8'h80, 8'h01);
    collect(0);
    chk("ssub_o", 32'(res[0]), 32'h17F);
    chk("ssub_d8_lat", lat[3], 1);

    go(1'b0, 1'b1, 8'h10, 8'h0F);
    collect(0);
    chk("m4_sadd_o", 32'(res[1]), 32'h00F);
    chk("m4_sadd_lat", lat[1], 4);
    go(1'b0, 1'b0, 8'h10, 8'h0F);
    collect(0);
    chk("m4_uadd_o", 32'(res[1]), 32'h01F);

    // start held high: second op starts straight out of DONE
    @(negedge clk);
    start = 1'b1; sub = 1'b1; sgn = 1'b0; a = 8'h05; b = 8'h07;
    @(negedge clk);
    sub = 1'b0; a = 8'hC8; b = 8'h64;
    t1 = 0; t2 = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 20 && t2 == 0; c++) begin
      @(negedge clk);
      if (done_v[0]) begin
        if (t1 == 0) begin
          t1 = c; r1 = o[0];
        end else begin
          t2 = c; r2 = o[0]; start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_lat", t1, 4);
    chk("b2b_first_o", 32'(r1), 32'h1FE);
    chk("b2b_gap", t2 - t1, 5);
    chk("b2b_second_o", 32'(r2), 32'h12C);
    repeat (12) @(negedge clk);

    go(1'b1, 1'b1, 8'h80, 8'h01);
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    collect(2);
    chk("ignore_o", 32'(res[0]), 32'h17F);
    chk("ignore_lat", lat[0], 4);
    repeat (12) @(negedge clk);

    go(1'b0, 1'b0, 8'hC8, 8'h64);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_o", 32'(o[0]), 32'h0);
    chk("abort_busy", 32'(busy_v[0]), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    collect(0);
    chk("abort_no_done", lat[0], 0);
    go(1'b0, 1'b1, 8'h80, 8'h01);
    collect(0);
    chk("after_rst_o", 32'(res[0]), 32'h181);
    chk("after_rst_lat", lat[0], 4);

    for (int k = 0; k < 8; k++) begin
      logic       rs, rg;
      logic [7:0] ra, rb;
      rs = 1'($urandom_range(1));
      rg = 1'($urandom_range(1));
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      go(rs, rg, ra, rb);
      collect(0);
      chk("rnd_d1_o", 32'(res[2]), 32'(model(rs, rg, ra, rb)));
      chk("rnd_d1_lat", lat[2], 8);
      chk("rnd_d8_o", 32'(res[3]), 32'(model(rs, rg, ra, rb)));
      chk("rnd_d8_lat", lat[3], 1);
      chk("rnd_d2_o", 32'(res[0]), 32'(model(rs, rg, ra, rb)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digit_serial_add_sub.md
DIGIT_SERIAL_ADD_SUB -- requirements
Module: digit_serial_add_sub

Interface
REQ-001 Parameter N, default 8: width of operand A and of the low result field, N >= 2.
REQ-002 Parameter M, default N: width of operand B, 1 <= M <= N.
REQ-003 Parameter D, default 2: digit width processed per cycle, 1 <= D <= N, N divisible by D.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: asynchronous, active-low reset.
REQ-006 Port start  input  1: request a new operation; sampled only when not busy.
REQ-007 Port sub  input  1: 1 = A-B, 0 = A+B; captured with start.
REQ-008 Port sgn  input  1: 1 = two's-complement operands, 0 = unsigned; captured with start.
REQ-009 Port A  input  N: first operand; captured with start.
REQ-010 Port B  input  M: second operand; captured with start.
REQ-011 Port O  output  N+1: full-precision result, O[N] is the extension bit.
REQ-012 Port busy  output  1: high while an operation is in progress.
REQ-013 Port done  output  1: single-cycle pulse marking that O holds a new result.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE.
REQ-015 IDLE or DONE with start=1: SHALL capture A, B, sub, sgn, set carry = sub, clear digit counter, go to RUN.
REQ-016 B SHALL be extended to N bits: sign-extended when sgn=1, zero-extended when sgn=0.
REQ-017 In RUN, each cycle SHALL process D bits, LSB-first: digit of A + digit of (BB XOR {D{sub}}) + carry; sum digit written into O[N-1:0], carry register updated.
REQ-018 RUN SHALL last exactly N/D cycles; on the final digit, go to DONE.
REQ-019 Entering DONE, O[N] SHALL be: unsigned add -> CO; unsigned sub -> ~CO; signed (add or sub) -> CO if A[N-1] equals the MSB of the inverted-or-not BB, else O[N-1].
REQ-020 done SHALL be 1 only in DONE (one cycle); busy SHALL be 1 only in RUN.
REQ-021 DONE without start SHALL return to IDLE; DONE with start SHALL start the next operation directly (back-to-back, no idle cycle).
REQ-022 start while busy SHALL be ignored; captured operands and mode SHALL NOT change.
REQ-023 O SHALL hold the last completed result in IDLE until the next operation's first digit overwrites it; intermediate O values during RUN are not defined as valid.
REQ-024 Latency: start sampled at edge k -> done high for the cycle after edge k+N/D.
REQ-025 D = N SHALL give a single RUN cycle (latency 1) with identical results.

Reset
REQ-026 rst low SHALL immediately force state IDLE, O = 0, busy = 0, done = 0, carry = 0, counter = 0, regardless of clock.
REQ-027 Reset during RUN SHALL abort the operation; no done pulse SHALL follow the release of reset.
REQ-028 The first start after rst returns high SHALL be accepted at the next rising edge.

Structure
REQ-029 The FSM state encodings and the operation-mode encodings (sub, sgn) SHALL live in the shared library package/header, for reuse by the serial multiplier and comparator blocks.
REQ-030 One combinational sub-module, add_digit (D-bit sum with carry-in/carry-out), SHALL implement the per-cycle slice; the extension logic and FSM stay in digit_serial_add_sub.
REQ-031 Digit selection SHALL use a shift register of the captured operands, not a variable-index mux.

Verification (N=8, M=8, D=2 unless stated)
REQ-032 Unsigned sub, A=8'h05, B=8'h07 -> O=9'h1FE, done 4 cycles after start.
REQ-033 Unsigned add, A=8'hC8, B=8'h64 -> O=9'h12C; signed sub, A=8'h80, B=8'h01 -> O=9'h17F.
REQ-034 M=4: signed add A=8'h10, B=4'hF -> O=9'h00F; unsigned add same values -> O=9'h01F.
REQ-035 Back-to-back: start held high across DONE -> second result done exactly 5 cycles after first; start pulses during RUN ignored, result unchanged.
REQ-036 rst asserted at the 2nd RUN cycle -> O=0, busy=0 immediately; no done after release; next start yields correct result.
REQ-037 D=1 and D=8 random regression (sgn, sub random) -> O equals the exact (N+1)-bit arithmetic reference, latency 8 and 1 respectively.
